// File: rtl/wfetch_pkg.sv
// Shared widths and FSM encoding for the dense-layer weight fetcher.
package wfetch_pkg;
    localparam int NUM_WEIGHTS_DEF = 507;
    localparam int ADDR_W_DEF      = 10;
    localparam int DATA_W_DEF      = 8;
    localparam int FIFO_DEPTH_DEF  = 2;

    typedef logic [1:0] wfetch_state_t;

    localparam wfetch_state_t ST_IDLE  = 2'd0;
    localparam wfetch_state_t ST_FETCH = 2'd1;
    localparam wfetch_state_t ST_DRAIN = 2'd2;
    localparam wfetch_state_t ST_DONE  = 2'd3;
endpackage

// File: rtl/dense_weight_fetcher_if.sv
// Control, weight-memory and output-stream signals of the weight fetcher.
interface dense_weight_fetcher_if
    import wfetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    // Stream: a beat moves on any cycle with m_valid && m_ready; while m_valid is
    // high and m_ready low, m_data/m_last are held and m_valid never drops.
    modport master (
        input  start, base_addr, length, mem_rdata, m_ready,
        output busy, done, mem_en, mem_addr, m_valid, m_data, m_last
    );
    modport slave (
        output start, base_addr, length, mem_rdata, m_ready,
        input  busy, done, mem_en, mem_addr, m_valid, m_data, m_last
    );
endinterface

// File: rtl/wfetch_fifo.sv
// Small synchronous FIFO holding {last, data} beats between the memory and the stream.
module wfetch_fifo
    import wfetch_pkg::*;
#(
    parameter int W     = DATA_W_DEF + 1,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/dense_weight_fetcher.sv
// Weight-memory read sequencer streaming LEN words from BASE (wrapping) over valid/ready.
// Optional build macro WFETCH_STALL_CNT_EN adds the stall_cycles counter port.
module dense_weight_fetcher
    import wfetch_pkg::*;
#(
    parameter int NUM_WEIGHTS = NUM_WEIGHTS_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    dense_weight_fetcher_if.master bus,
    output wfetch_state_t         state_dbg
`ifdef WFETCH_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    wfetch_state_t     state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   rd_cnt;
    logic              inflight;
    logic              inflight_last;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W:0]   fifo_head;
    logic              start_ok;
    logic              pop;
    logic              issue;
    logic              last_rd;

    assign start_ok = (state == ST_IDLE) && bus.start;
    assign pop      = bus.m_valid && bus.m_ready;
    assign last_rd  = (rd_cnt == len_q - (ADDR_W + 1)'(1));

    // Credit check counts the beat leaving this cycle, so m_ready feeds mem_en directly.
    assign issue = (state == ST_FETCH) &&
                   (int'(fifo_count) + int'(inflight) < FIFO_DEPTH + int'(pop));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            addr          <= '0;
            len_q         <= '0;
            rd_cnt        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && last_rd;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        addr   <= bus.base_addr;
                        len_q  <= bus.length;
                        rd_cnt <= '0;
                        state  <= (bus.length == '0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (issue) begin
                        addr   <= (addr == ADDR_W'(NUM_WEIGHTS - 1)) ? '0 : addr + 1'b1;
                        rd_cnt <= rd_cnt + 1'b1;
                        if (last_rd) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && bus.m_last) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    wfetch_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .din   ({inflight_last, bus.mem_rdata}),
        .count (fifo_count),
        .head  (fifo_head)
    );

    assign bus.mem_en   = issue;
    assign bus.mem_addr = addr;
    assign bus.m_valid  = (fifo_count != '0);
    assign bus.m_data   = bus.m_valid ? fifo_head[DATA_W-1:0] : '0;
    assign bus.m_last   = bus.m_valid && fifo_head[DATA_W];
    assign bus.busy     = (state == ST_FETCH) || (state == ST_DRAIN);
    assign bus.done     = (state == ST_DONE);
    assign state_dbg    = state;

`ifdef WFETCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            stall_cycles <= '0;
        end else if (bus.m_valid && !bus.m_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_dense_weight_fetcher.sv
// Directed bench for dense_weight_fetcher with a behavioural 1-cycle weight ROM.
module tb_dense_weight_fetcher;
    import wfetch_pkg::*;

    localparam int NW    = 507;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    wfetch_state_t state_dbg;
`ifdef WFETCH_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    dense_weight_fetcher_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dense_weight_fetcher #(
        .NUM_WEIGHTS (NW),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.master),
        .state_dbg    (state_dbg)
`ifdef WFETCH_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // weight ROM: word = (3*addr + 1) mod 256, one-cycle read latency
    function automatic logic [DW-1:0] rom(input int a);
        logic [31:0] t;
        t = a * 3 + 1;
        return t[DW-1:0];
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_rdata <= rom(int'(bus.mem_addr));
    end

    // scoreboard state
    int checks = 0;
    int errors = 0;
    logic [DW:0]   exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            addr_cyc[$];
    int            beat_cyc[$];
    int            done_cyc[$];
    logic          done_busy[$];
    int            extra_beats = 0;
    logic          prev_stall = 1'b0;
    logic [DW:0]   prev_beat = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // monitor at the falling edge, away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("occupancy", 32'((int'(dut.fifo_count) + int'(dut.inflight)) <= DEPTH), 32'd1);
            if (bus.mem_en) begin
                addr_q.push_back(bus.mem_addr);
                addr_cyc.push_back(cyc);
            end
            if (bus.done) begin
                done_cyc.push_back(cyc);
                done_busy.push_back(bus.busy);
            end
            if (prev_stall)
                check("hold", 32'({bus.m_valid, bus.m_last, bus.m_data}), 32'({1'b1, prev_beat}));
            if (bus.m_valid && bus.m_ready) begin
                beat_cyc.push_back(cyc);
                if (exp_q.size() != 0) check("beat", 32'({bus.m_last, bus.m_data}), 32'(exp_q.pop_front()));
                else extra_beats++;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_beat  = {bus.m_last, bus.m_data};
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        addr_q.delete();
        addr_cyc.delete();
        beat_cyc.delete();
        done_cyc.delete();
        done_busy.delete();
        extra_beats = 0;
    endtask

    task automatic fill_exp(input int base, input int len);
        for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), rom((base + i) % NW)});
    endtask

    task automatic start_xfer(input int base, input int len, output int s);
        bus.start     = 1'b1;
        bus.base_addr = AW'(base);
        bus.length    = (AW + 1)'(len);
        s = cyc;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int n;
        n = 0;
        while (done_cyc.size() == 0 && n < budget) begin
            bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
        end
        bus.m_ready = 1'b1;
        check("done_timeout", 32'(done_cyc.size() > 0), 32'd1);
    endtask

    task automatic check_addrs(input int base, input int len);
        check("addr_count", 32'(addr_q.size()), 32'(len));
        for (int i = 0; i < addr_q.size() && i < len; i++)
            check("addr", 32'(addr_q[i]), 32'((base + i) % NW));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},  32'(bus.busy),     32'd0);
        check({tag, "_done"},  32'(bus.done),     32'd0);
        check({tag, "_en"},    32'(bus.mem_en),   32'd0);
        check({tag, "_addr"},  32'(bus.mem_addr), 32'd0);
        check({tag, "_valid"}, 32'(bus.m_valid),  32'd0);
        check({tag, "_data"},  32'(bus.m_data),   32'd0);
        check({tag, "_last"},  32'(bus.m_last),   32'd0);
        check({tag, "_state"}, 32'(state_dbg),    32'(ST_IDLE));
    endtask

    initial begin
        int s;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.m_ready   = 1'b1;
        bus.mem_rdata = '0;
        rst = 1'b1;
        repeat (3) step();
        check_zero_outputs("reset");
        rst = 1'b0;
        step();

        // base 0, len 4, ready high: back-to-back reads and beats, done one cycle after last
        clear_sb();
        fill_exp(0, 4);
        start_xfer(0, 4, s);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        wait_done(50, 1'b0);
        check_addrs(0, 4);
        for (int i = 0; i < addr_cyc.size() && i < 4; i++) check("addr_cycle", 32'(addr_cyc[i]), 32'(s + 1 + i));
        check("beats_len4", 32'(beat_cyc.size()), 32'd4);
        for (int i = 0; i < beat_cyc.size() && i < 4; i++) check("beat_cycle", 32'(beat_cyc[i]), 32'(s + 3 + i));
        if (done_cyc.size() > 0) begin
            check("done_cycle", 32'(done_cyc[0]), 32'(s + 7));
            check("busy_in_done", 32'(done_busy[0]), 32'd0);
        end
        check("exp_left_len4", 32'(exp_q.size()), 32'd0);
        step();
        check("done_pulse_width", 32'(bus.done), 32'd0);

        // base 505, len 4: address wraps after 506
        clear_sb();
        exp_q.push_back({1'b0, 8'd236});
        exp_q.push_back({1'b0, 8'd239});
        exp_q.push_back({1'b0, 8'd1});
        exp_q.push_back({1'b1, 8'd4});
        start_xfer(505, 4, s);
        wait_done(50, 1'b0);
        check("wrap_count", 32'(addr_q.size()), 32'd4);
        if (addr_q.size() == 4) begin
            check("wrap_a0", 32'(addr_q[0]), 32'd505);
            check("wrap_a1", 32'(addr_q[1]), 32'd506);
            check("wrap_a2", 32'(addr_q[2]), 32'd0);
            check("wrap_a3", 32'(addr_q[3]), 32'd1);
        end
        check("exp_left_wrap", 32'(exp_q.size()), 32'd0);
        step();

        // len 8 with random backpressure
        clear_sb();
        fill_exp(123, 8);
        start_xfer(123, 8, s);
        wait_done(400, 1'b1);
        check_addrs(123, 8);
        check("beats_rand", 32'(beat_cyc.size()), 32'd8);
        check("exp_left_rand", 32'(exp_q.size()), 32'd0);
        step();

        // len 0: done the cycle after start, no reads, no beats
        clear_sb();
        start_xfer(7, 0, s);
        repeat (4) step();
        check("len0_done_count", 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() > 0) check("len0_done_cycle", 32'(done_cyc[0]), 32'(s + 1));
        check("len0_reads", 32'(addr_q.size()), 32'd0);
        check("len0_beats", 32'(beat_cyc.size()), 32'd0);

        // start while busy is ignored
        clear_sb();
        fill_exp(100, 6);
        start_xfer(100, 6, s);
        repeat (3) step();
        start_xfer(300, 3, s);
        wait_done(80, 1'b0);
        repeat (8) step();
        check_addrs(100, 6);
        check("busy_start_beats", 32'(beat_cyc.size()), 32'd6);
        check("busy_start_dones", 32'(done_cyc.size()), 32'd1);
        check("exp_left_busy", 32'(exp_q.size()), 32'd0);

        // reset after third beat of len 10, then a clean restart
        clear_sb();
        fill_exp(40, 10);
        start_xfer(40, 10, s);
        for (int n = 0; n < 50 && beat_cyc.size() < 3; n++) step();
        check("pre_reset_beats", 32'(beat_cyc.size() >= 3), 32'd1);
        rst = 1'b1;
        step();
        check_zero_outputs("midrst");
        rst = 1'b0;
        clear_sb();
        step();
        check("post_rst_valid", 32'(bus.m_valid), 32'd0);
        check("post_rst_en", 32'(bus.mem_en), 32'd0);
        step();
        check("post_rst_valid2", 32'(bus.m_valid), 32'd0);
        fill_exp(200, 5);
        start_xfer(200, 5, s);
        wait_done(60, 1'b0);
        check_addrs(200, 5);
        if (addr_cyc.size() > 0) check("restart_first_en", 32'(addr_cyc[0]), 32'(s + 1));
        check("restart_beats", 32'(beat_cyc.size()), 32'd5);
        check("exp_left_restart", 32'(exp_q.size()), 32'd0);
        step();
        check("extra_beats", 32'(extra_beats), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
